// File: rtl/mac_dot_seq.sv
// mac_dot_seq: sequences CLEAR / ADD* / READ on the mul_add unit to form a float dot product
// Ports:
//   clk, aclr_n                      clock, asynchronous active-low reset
//   in_valid/in_ready/in_a/in_b      operand-pair push into the internal FIFO
//   go, len                          start pulse and pair count (clamped to DEPTH)
//   busy, res_valid, res             sequence status, result pulse, held result
//   err, err_clr                     sticky timeout flag and its clear
//   mac_clk_en/start/n/dataa/datab   command side of mul_add
//   mac_result, mac_done             response side of mul_add
module mac_dot_seq #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          aclr_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_a,
    input  logic [31:0]   in_b,
    input  logic          go,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          res_valid,
    output logic [31:0]   res,
    output logic          err,
    input  logic          err_clr,
    output logic          mac_clk_en,
    output logic          mac_start,
    output logic [4:0]    mac_n,
    output logic [31:0]   mac_dataa,
    output logic [31:0]   mac_datab,
    input  logic [31:0]   mac_result,
    input  logic          mac_done
);
    localparam int          TW       = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] DEPTH_C  = (AW + 1)'(DEPTH);
    localparam logic [4:0]  OP_CLEAR = 5'd0;
    localparam logic [4:0]  OP_ADD   = 5'd1;
    localparam logic [4:0]  OP_READ  = 5'd2;

    typedef enum logic [2:0] {
        IDLE, CLR_ISSUE, CLR_WAIT, ADD_ISSUE, ADD_WAIT, RD_ISSUE, RD_WAIT, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   rem_q, rem_d;
    logic [TW-1:0] wcnt_q, wcnt_d;
    logic [31:0]   res_q, res_d;
    logic          err_q, err_d;
    logic          start_q, start_d;
    logic [4:0]    n_q, n_d;
    logic [31:0]   a_q, a_d, b_q, b_d;

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   count_q, count_d;
    logic          in_ready_q, in_ready_d;
    logic          push, pop, flush, empty;

    assign empty      = count_q == '0;
    assign in_ready   = in_ready_q;
    assign busy       = state_q != IDLE;
    assign mac_clk_en = state_q != IDLE;
    assign res_valid  = state_q == DONE;
    assign res        = res_q;
    assign err        = err_q;
    assign mac_start  = start_q;
    assign mac_n      = n_q;
    assign mac_dataa  = a_q;
    assign mac_datab  = b_q;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        wcnt_d  = wcnt_q;
        res_d   = res_q;
        err_d   = err_clr ? 1'b0 : err_q;
        start_d = 1'b0;
        n_d     = n_q;
        a_d     = a_q;
        b_d     = b_q;
        pop     = 1'b0;
        flush   = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) begin
                    rem_d   = len > DEPTH_C ? DEPTH_C : len;
                    state_d = CLR_ISSUE;
                end
            end
            CLR_ISSUE, RD_ISSUE: begin
                start_d = 1'b1;
                n_d     = state_q == CLR_ISSUE ? OP_CLEAR : OP_READ;
                a_d     = '0;
                b_d     = '0;
                wcnt_d  = '0;
                state_d = state_q == CLR_ISSUE ? CLR_WAIT : RD_WAIT;
            end
            ADD_ISSUE: begin
                // stall here without a start until a pair is available
                if (!empty) begin
                    start_d    = 1'b1;
                    n_d        = OP_ADD;
                    {a_d, b_d} = mem_q[rd_q];
                    pop        = 1'b1;
                    rem_d      = rem_q - (AW + 1)'(1);
                    wcnt_d     = '0;
                    state_d    = ADD_WAIT;
                end
            end
            CLR_WAIT, ADD_WAIT, RD_WAIT: begin
                // a done arriving on the last allowed cycle still counts as success
                if (mac_done) begin
                    state_d = state_q == RD_WAIT ? DONE : rem_q != '0 ? ADD_ISSUE : RD_ISSUE;
                    res_d   = state_q == RD_WAIT ? mac_result : res_q;
                end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    flush   = 1'b1;
                    rem_d   = '0;
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + TW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        push       = in_valid && in_ready_q;
        count_d    = flush ? '0 : count_q + (AW + 1)'(push) - (AW + 1)'(pop);
        wr_d       = flush ? '0 : wr_q + AW'(push);
        rd_d       = flush ? '0 : rd_q + AW'(pop);
        in_ready_d = count_d != DEPTH_C;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {in_a, in_b};
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            wcnt_q     <= '0;
            res_q      <= '0;
            err_q      <= 1'b0;
            start_q    <= 1'b0;
            n_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            wcnt_q     <= wcnt_d;
            res_q      <= res_d;
            err_q      <= err_d;
            start_q    <= start_d;
            n_q        <= n_d;
            a_q        <= a_d;
            b_q        <= b_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end
endmodule

// File: tb/tb_mac_dot_seq.sv
// tb_mac_dot_seq: directed bench for mac_dot_seq with a behavioural mul_add model
module tb_mac_dot_seq;
    logic        clk = 1'b0, aclr_n = 1'b0, in_valid = 1'b0, go = 1'b0, err_clr = 1'b0;
    logic [31:0] in_a = '0, in_b = '0;
    logic [4:0]  len = '0;
    logic        in_ready, busy, res_valid, err, mac_clk_en, mac_start, mac_done;
    logic [31:0] res, mac_dataa, mac_datab, mac_result;
    logic [4:0]  mac_n;

    int vectors = 0, miscompares = 0;

    mac_dot_seq dut (
        .clk(clk), .aclr_n(aclr_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .go(go), .len(len), .busy(busy),
        .res_valid(res_valid), .res(res), .err(err), .err_clr(err_clr),
        .mac_clk_en(mac_clk_en), .mac_start(mac_start), .mac_n(mac_n),
        .mac_dataa(mac_dataa), .mac_datab(mac_datab),
        .mac_result(mac_result), .mac_done(mac_done)
    );

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] x);
        logic [10:0] e;
        e = {3'b0, x[30:23]} + 11'd896;
        if (x[30:23] == 8'd0) return 0.0;
        return $bitstoreal({x[31], e, x[22:0], 29'b0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return 32'd0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // mul_add model: done pulses 5 cycles after start
    bit          model_en = 1'b1;
    int          mcnt;
    logic [4:0]  mop;
    logic [31:0] ma, mb;
    real         acc;
    always @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            mcnt       <= 0;
            mac_done   <= 1'b0;
            mac_result <= '0;
            acc        <= 0.0;
        end else begin
            mac_done <= 1'b0;
            if (mac_start && mac_clk_en) begin
                mcnt <= 5;
                mop  <= mac_n;
                ma   <= mac_dataa;
                mb   <= mac_datab;
            end else if (mcnt != 0) begin
                mcnt <= mcnt - 1;
                if (mcnt == 1 && model_en) begin
                    mac_done <= 1'b1;
                    if (mop == 5'd0) acc <= 0.0;
                    else if (mop == 5'd1) acc <= acc + f2r(ma) * f2r(mb);
                    else mac_result <= r2f(acc);
                end
            end
        end
    end

    logic [4:0] seq[$];
    int         rv_cnt = 0;
    always @(negedge clk) begin
        if (mac_start) seq.push_back(mac_n);
        if (res_valid) rv_cnt++;
    end

    function automatic logic [31:0] seq_code();
        logic [31:0] c;
        c = '0;
        foreach (seq[i]) c = (c << 4) | {27'b0, seq[i]};
        return c;
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        int t = 0;
        while (!in_ready && t < 50) begin
            step();
            t++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL push_wait: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_go(input logic [4:0] l);
        go  = 1'b1;
        len = l;
        step();
        go  = 1'b0;
    endtask

    task automatic wait_res();
        int s = rv_cnt;
        int t = 0;
        while (rv_cnt == s && t < 3000) begin
            step();
            t++;
        end
        vectors++;
        if (rv_cnt == s) begin
            miscompares++;
            $display("FAIL res_wait: res_valid count=%0d required >%0d", rv_cnt, s);
        end
    endtask

    task automatic test_reset();
        aclr_n = 1'b0;
        step(2);
        vectors++;
        if ({in_ready, busy, res_valid, err, mac_clk_en, mac_start, mac_n, res, mac_dataa, mac_datab} !== '0) begin
            miscompares++;
            $display("FAIL reset_outs: rdy=%b busy=%b rv=%b err=%b ce=%b st=%b n=%h res=%h a=%h b=%h required all 0",
                     in_ready, busy, res_valid, err, mac_clk_en, mac_start, mac_n, res, mac_dataa, mac_datab);
        end
        aclr_n = 1'b1;
        step(2);
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_rdy: got %b want 1", in_ready); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_dot2();
        int r0 = rv_cnt;
        seq.delete();
        push(32'h40C00000, 32'h40800000);
        push(32'h40000000, 32'h40400000);
        do_go(5'd2);
        wait_res();
        step(3);
        vectors++;
        if (res !== 32'h41F00000) begin miscompares++; $display("FAIL dot2_res: got %h want 41f00000", res); end
        vectors++;
        if (seq.size() !== 4 || seq_code() !== 32'h0112) begin
            miscompares++;
            $display("FAIL dot2_seq: got n=%0d code=%h want n=4 code=0112", seq.size(), seq_code());
        end
        vectors++;
        if (rv_cnt - r0 !== 1) begin miscompares++; $display("FAIL dot2_rvcnt: got %0d want 1", rv_cnt - r0); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL dot2_busy: got %b want 0", busy); end
    endtask

    task automatic test_stall();
        seq.delete();
        push(32'h3F800000, 32'h40000000);
        do_go(5'd3);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL stall_busy_go: got %b want 1", busy); end
        step(40);
        vectors++;
        if (busy !== 1'b1 || seq.size() !== 2) begin
            miscompares++;
            $display("FAIL stall_hold: busy=%b starts=%0d want busy=1 starts=2", busy, seq.size());
        end
        // second push lands on the cycle the stalled ADD pops the first one
        push(32'h40400000, 32'h40400000);
        push(32'h3F000000, 32'h40800000);
        wait_res();
        vectors++;
        if (res !== 32'h41500000) begin miscompares++; $display("FAIL stall_res: got %h want 41500000", res); end
        vectors++;
        if (seq.size() !== 5 || seq_code() !== 32'h01112) begin
            miscompares++;
            $display("FAIL stall_seq: got n=%0d code=%h want n=5 code=01112", seq.size(), seq_code());
        end
    endtask

    task automatic test_len_zero();
        seq.delete();
        do_go(5'd0);
        wait_res();
        vectors++;
        if (res !== 32'h0) begin miscompares++; $display("FAIL len0_res: got %h want 00000000", res); end
        vectors++;
        if (seq.size() !== 2 || seq_code() !== 32'h02) begin
            miscompares++;
            $display("FAIL len0_seq: got n=%0d code=%h want n=2 code=02", seq.size(), seq_code());
        end
    endtask

    task automatic test_full();
        seq.delete();
        for (int i = 0; i < 15; i++) push(32'h3F800000, 32'h3F800000);
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL full_15: in_ready=%b want 1", in_ready); end
        push(32'h3F800000, 32'h3F800000);
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_16: in_ready=%b want 0", in_ready); end
        in_valid = 1'b1;
        in_a     = 32'h40000000;
        in_b     = 32'h41000000;
        step(3);
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_17: in_ready=%b want 0", in_ready); end
        do_go(5'd20);
        wait_res();
        vectors++;
        if (res !== 32'h41800000) begin miscompares++; $display("FAIL full_res: got %h want 41800000", res); end
        vectors++;
        if (seq.size() !== 18) begin miscompares++; $display("FAIL full_starts: got %0d want 18", seq.size()); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL full_drain: in_ready=%b want 1", in_ready); end
    endtask

    task automatic test_timeout();
        int r0 = rv_cnt;
        int t = 0;
        model_en = 1'b0;
        seq.delete();
        push(32'h40000000, 32'h40000000);
        push(32'h40000000, 32'h40000000);
        do_go(5'd2);
        step(200);
        vectors++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL to_early: err=%b busy=%b want err=0 busy=1", err, busy);
        end
        while (!err && t < 100) begin
            step();
            t++;
        end
        vectors++;
        if (err !== 1'b1 || t < 54 || t > 58) begin
            miscompares++;
            $display("FAIL to_err: err=%b after %0d more cycles want err=1 after 54..58", err, t);
        end
        vectors++;
        if (busy !== 1'b0 || rv_cnt !== r0 || seq.size() !== 1) begin
            miscompares++;
            $display("FAIL to_abort: busy=%b res_valids=%0d starts=%0d want 0,0,1", busy, rv_cnt - r0, seq.size());
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL to_clr: err=%b want 0", err); end
        model_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int r0;
        int t = 0;
        seq.delete();
        do_go(5'd1);
        step(40);
        vectors++;
        if (busy !== 1'b1 || seq.size() !== 1) begin
            miscompares++;
            $display("FAIL flush_empty: busy=%b starts=%0d want busy=1 starts=1", busy, seq.size());
        end
        push(32'h40A00000, 32'h3E800000);
        while (!(mac_start && mac_n == 5'd1) && t < 50) begin
            step();
            t++;
        end
        vectors++;
        if (!(mac_start && mac_n == 5'd1)) begin
            miscompares++;
            $display("FAIL mid_add_wait: start=%b n=%0d want start=1 n=1", mac_start, mac_n);
        end
        r0 = rv_cnt;
        #2 aclr_n = 1'b0;
        #1;
        vectors++;
        if (mac_start !== 1'b0 || busy !== 1'b0 || mac_clk_en !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: start=%b busy=%b ce=%b want 0,0,0", mac_start, busy, mac_clk_en);
        end
        step(2);
        aclr_n = 1'b1;
        step(2);
        vectors++;
        if (rv_cnt !== r0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_quiet: res_valids=%0d busy=%b want 0,0", rv_cnt - r0, busy);
        end
        seq.delete();
        push(32'h40A00000, 32'h3E800000);
        do_go(5'd1);
        wait_res();
        vectors++;
        if (res !== 32'h3FA00000) begin miscompares++; $display("FAIL mid_rerun_res: got %h want 3fa00000", res); end
        vectors++;
        if (seq.size() !== 3 || seq_code() !== 32'h012) begin
            miscompares++;
            $display("FAIL mid_rerun_seq: got n=%0d code=%h want n=3 code=012", seq.size(), seq_code());
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_dot2();
        test_stall();
        test_len_zero();
        test_full();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
